// File: rtl/pool_engine_if.sv
// Streaming handshake bundle for pool_engine: input beat channel and result channel.
interface pool_engine_if #(
  parameter int unsigned depth = 3,
  parameter int unsigned W     = 16
) ();
  localparam int unsigned D = 1 << depth;

  logic [W*D-1:0] ip;
  logic           ipValid;
  logic           ipReady;
  logic [W*D-1:0] op;
  logic           opValid;
  logic           opReady;

  modport slave (
    input  ip,
    input  ipValid,
    output ipReady,
    output op,
    output opValid,
    input  opReady
  );

  modport master (
    output ip,
    output ipValid,
    input  ipReady,
    input  op,
    input  opValid,
    output opReady
  );
endinterface

// File: rtl/pool_engine.sv
// Per-lane windowed pooling engine: max / average / saturating sum / bypass over
// 1<<winShift beats, with a registered result and a zero-bubble handshake.
module pool_engine #(
  parameter int unsigned depth = 3,
  parameter int unsigned W     = 16,
  parameter int unsigned WS    = 2,
  localparam int unsigned D    = 1 << depth,
  localparam int unsigned SW   = (WS > 0) ? $clog2(WS + 1) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  pool_engine_if.slave  bus,
  input  logic [1:0]    mode,
  input  logic [SW-1:0] winShift,
  input  logic          flush,
  output logic          busy
);
  localparam int unsigned AW = W + WS;

  typedef enum logic {StAcc, StOut} state_e;

  state_e               state_q, state_d;
  logic [WS:0]          count_q, count_d;
  logic [1:0]           mode_q, mode_d;
  logic [SW-1:0]        shift_q, shift_d;
  logic signed [AW-1:0] acc_q [D];
  logic signed [AW-1:0] acc_d [D];
  logic [W*D-1:0]       op_q, op_d;

  logic                 first, in_ready, accept, closing;
  logic [SW-1:0]        lim_shift, cur_shift;
  logic [1:0]           cur_mode;
  logic signed [W-1:0]  xw  [D];
  logic signed [AW-1:0] x   [D];
  logic signed [AW-1:0] nxt [D];
  logic signed [AW-1:0] avg [D];
  logic [W*D-1:0]       res;

  always_comb begin
    first     = (count_q == '0);
    lim_shift = (32'(winShift) > WS) ? SW'(WS) : winShift;
    // Window shape is latched on the first beat; later beats reuse the held copy.
    cur_mode  = first ? mode : mode_q;
    cur_shift = first ? ((mode == 2'd3) ? '0 : lim_shift) : shift_q;
    in_ready  = (state_q == StAcc && !flush) || (state_q == StOut && bus.opReady);
    accept    = bus.ipValid && in_ready;
    closing   = (count_q + (WS+1)'(1)) == ((WS+1)'(1) << cur_shift);
    res       = '0;

    for (int i = 0; i < D; i++) begin
      xw[i] = bus.ip[W*i +: W];
      x[i]  = AW'(xw[i]);
      unique case (cur_mode)
        2'd0:    nxt[i] = (first || x[i] > acc_q[i]) ? x[i] : acc_q[i];
        2'd3:    nxt[i] = x[i];
        default: nxt[i] = first ? x[i] : acc_q[i] + x[i];
      endcase
      avg[i] = nxt[i] >>> cur_shift;
      unique case (cur_mode)
        2'd1: res[W*i +: W] = avg[i][W-1:0];
        2'd2: begin
          if ((&nxt[i][AW-1:W-1]) || !(|nxt[i][AW-1:W-1])) res[W*i +: W] = nxt[i][W-1:0];
          else if (nxt[i][AW-1])                           res[W*i +: W] = {1'b1, {(W-1){1'b0}}};
          else                                             res[W*i +: W] = {1'b0, {(W-1){1'b1}}};
        end
        default: res[W*i +: W] = nxt[i][W-1:0];
      endcase
    end

    state_d = state_q;
    count_d = count_q;
    mode_d  = mode_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    op_d    = op_q;

    if (state_q == StOut && bus.opReady && !accept) state_d = StAcc;

    if (state_q == StAcc && flush) begin
      count_d = '0;
      for (int i = 0; i < D; i++) acc_d[i] = '0;
    end else if (accept) begin
      mode_d  = cur_mode;
      shift_d = cur_shift;
      acc_d   = nxt;
      if (closing) begin
        count_d = '0;
        op_d    = res;
        state_d = StOut;
      end else begin
        count_d = count_q + (WS+1)'(1);
        state_d = StAcc;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StAcc;
      count_q <= '0;
      mode_q  <= '0;
      shift_q <= '0;
      op_q    <= '0;
      for (int i = 0; i < D; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      shift_q <= shift_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.ipReady = in_ready;
  assign bus.op      = op_q;
  assign bus.opValid = (state_q == StOut);
  assign busy        = (count_q != '0) || (state_q == StOut);

endmodule

// File: tb/tb_pool_engine.sv
// Bench for pool_engine (D=2, W=16, WS=2): directed scenarios plus random traffic,
// all checked against a window-level reference model.
module tb_pool_engine;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] mode = '0;
  logic [1:0] winShift = '0;
  logic       flush = 1'b0;
  logic       busy;

  pool_engine_if #(.depth(1), .W(16)) bus ();

  pool_engine #(.depth(1), .W(16), .WS(2)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus),
    .mode     (mode),
    .winShift (winShift),
    .flush    (flush),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;

  int nassert = 0;
  int nfail   = 0;

  // Reference model: beats of the open window, its mode/length, and the held result.
  logic [31:0] wq[$];
  int          w_mode, w_shift;
  logic        m_hold;
  logic [31:0] m_res;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat(input int a, input int b);
    logic [31:0] r;
    r = {b[15:0], a[15:0]};
    return r;
  endfunction

  function automatic int lane(input logic [31:0] b, input int l);
    logic signed [15:0] v;
    v = b[16*l +: 16];
    return int'(v);
  endfunction

  function automatic logic [31:0] window_result();
    logic [31:0] r;
    int n, v, s, mx;
    n = wq.size();
    r = '0;
    for (int l = 0; l < 2; l++) begin
      s  = 0;
      mx = -100000;
      for (int k = 0; k < n; k++) begin
        v  = lane(wq[k], l);
        s += v;
        if (v > mx) mx = v;
      end
      case (w_mode)
        0: v = mx;
        1: v = (s >= 0) ? s / n : -((-s + n - 1) / n);
        2: v = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
        default: v = lane(wq[0], l);
      endcase
      r[16*l +: 16] = v[15:0];
    end
    return r;
  endfunction

  // One clock: drive inputs, compare at the falling edge, advance, update the model.
  task automatic cyc(input logic v, input logic [31:0] d, input logic [1:0] m,
                     input logic [1:0] s, input logic f, input logic r);
    logic exp_ready;
    bus.ipValid = v;
    bus.ip      = d;
    mode        = m;
    winShift    = s;
    flush       = f;
    bus.opReady = r;
    exp_ready   = m_hold ? r : !f;
    @(negedge CLK);
    chk("ipReady", 32'(bus.ipReady), 32'(exp_ready));
    chk("opValid", 32'(bus.opValid), 32'(m_hold));
    chk("busy", 32'(busy), 32'((wq.size() != 0) || m_hold));
    if (m_hold) chk("op", bus.op, m_res);
    @(posedge CLK);
    #1;
    if (!m_hold && f) begin
      wq.delete();
    end else begin
      if (m_hold && r) m_hold = 1'b0;
      if (v && exp_ready) begin
        if (wq.size() == 0) begin
          w_mode  = int'(m);
          w_shift = (m == 2'd3) ? 0 : ((s > 2'd2) ? 2 : int'(s));
        end
        wq.push_back(d);
        if (wq.size() == (1 << w_shift)) begin
          m_res  = window_result();
          m_hold = 1'b1;
          wq.delete();
        end
      end
    end
  endtask

  task automatic do_reset();
    RST         = 1'b1;
    bus.ipValid = 1'b0;
    bus.opReady = 1'b0;
    flush       = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    wq.delete();
    m_hold = 1'b0;
    #1;
    chk("rst_op", bus.op, 32'h0);
    chk("rst_opValid", 32'(bus.opValid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ipReady", 32'(bus.ipReady), 32'h1);
  endtask

  initial begin
    bus.ip      = '0;
    bus.ipValid = 1'b0;
    bus.opReady = 1'b0;
    m_hold      = 1'b0;
    m_res       = '0;
    w_mode      = 0;
    w_shift     = 0;
    do_reset();

    // Max over 4 beats.
    cyc(1, beat(3, -1), 0, 2, 0, 1);
    cyc(1, beat(-7, -9), 0, 2, 0, 1);
    cyc(1, beat(12, -4), 0, 2, 0, 1);
    chk("max_pre_valid", 32'(bus.opValid), 32'h0);
    cyc(1, beat(5, -2), 0, 2, 0, 1);
    chk("max_valid", 32'(bus.opValid), 32'h1);
    chk("max_op", bus.op, beat(12, -1));
    cyc(0, '0, 0, 2, 0, 1);

    // Average, floor toward minus infinity; back-to-back windows.
    cyc(1, beat(-3, 0), 1, 1, 0, 1);
    cyc(1, beat(-4, 0), 1, 1, 0, 1);
    chk("avg_neg", bus.op, beat(-4, 0));
    cyc(1, beat(7, 0), 1, 1, 0, 1);
    cyc(1, beat(8, 0), 1, 1, 0, 1);
    chk("avg_pos", bus.op, beat(7, 0));
    cyc(0, '0, 0, 0, 0, 1);

    // Saturating sum both directions.
    for (int k = 0; k < 4; k++) cyc(1, beat(32'h7000, 1), 2, 2, 0, 1);
    chk("sum_hi", bus.op, beat(32'h7FFF, 4));
    for (int k = 0; k < 4; k++) cyc(1, beat(32'h9000, -1), 2, 2, 0, 1);
    chk("sum_lo", bus.op, beat(32'h8000, -4));
    cyc(0, '0, 0, 0, 0, 1);

    // Bypass with backpressure, then streaming with no bubble.
    cyc(1, beat(10, 20), 3, 2, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(1, beat(11, 21), 3, 2, 0, 0);
      chk("byp_hold", bus.op, beat(10, 20));
    end
    for (int k = 0; k < 6; k++) begin
      cyc(1, beat(30 + k, k), 3, 2, 0, 1);
      chk("byp_stream_op", bus.op, beat(30 + k, k));
      chk("byp_stream_valid", 32'(bus.opValid), 32'h1);
    end
    cyc(0, '0, 0, 0, 0, 1);

    // Flush mid-window; pre-flush data must not leak.
    cyc(1, beat(100, 100), 0, 2, 0, 1);
    cyc(1, beat(50, 50), 0, 2, 0, 1);
    cyc(1, beat(99, 99), 0, 2, 1, 1);
    for (int k = 1; k <= 4; k++) cyc(1, beat(k, k), 0, 2, 0, 1);
    chk("flush_op", bus.op, beat(4, 4));
    cyc(0, '0, 0, 0, 0, 1);

    // Reset mid-window.
    cyc(1, beat(50, 50), 0, 2, 0, 1);
    cyc(1, beat(60, 60), 0, 2, 0, 1);
    cyc(1, beat(70, 70), 0, 2, 0, 1);
    do_reset();
    for (int k = 1; k <= 4; k++) cyc(1, beat(k, -k), 0, 2, 0, 1);
    chk("post_rst_op", bus.op, beat(4, -1));
    cyc(0, '0, 0, 0, 0, 1);

    // Random traffic: mode/winShift change every cycle to exercise mid-window holds.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] d;
      d = $urandom();
      if ($urandom_range(0, 3) == 0) d[15:0] = ($urandom_range(0, 1) == 0) ? 16'h7F00 : 16'h8100;
      cyc(($urandom_range(0, 3) != 0), d, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule

// File: doc/pool_engine.md
POOL_ENGINE -- requirements
Module: pool_engine

Interface
REQ-001 Parameter depth, default 3; lane count D = 1<<depth.
REQ-002 Parameter W, default 16; signed two's-complement lane width.
REQ-003 Parameter WS, default 2; max window shift; max window = 1<<WS beats.
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 ip  in  W*D  input beat; lane i = ip[W*i +: W].
REQ-007 ipValid  in  1  input beat present.
REQ-008 ipReady  out  1  engine accepts ip this cycle.
REQ-009 mode  in  2  0=max, 1=average, 2=saturating sum, 3=bypass.
REQ-010 winShift  in  clog2(WS+1)  window = 1<<winShift beats; values > WS clamp to WS.
REQ-011 flush  in  1  discard partial window.
REQ-012 op  out  W*D  result beat, lane-aligned with ip.
REQ-013 opValid  out  1  result present.
REQ-014 opReady  in  1  consumer accepts op.
REQ-015 busy  out  1  high when a partial window is held or a result is pending.

Function
REQ-016 Beat accepted on ipValid && ipReady; result consumed on opValid && opReady.
REQ-017 FSM states: ACC (collecting), OUT (result held); reset state ACC.
REQ-018 ipReady = (state==ACC) || (state==OUT && opReady).
REQ-019 mode and winShift sampled on first beat of each window (count==0); held for that window; mid-window changes ignored.
REQ-020 Beat counter width WS+1; increments per accepted beat; on reaching 1<<winShift the window closes, counter clears, state -> OUT.
REQ-021 Max mode: per-lane signed maximum over window beats; first beat loads accumulator directly.
REQ-022 Sum/average accumulator per lane is W+WS bits, sign-extended inputs; no overflow possible.
REQ-023 Average mode: op lane = accumulator arithmetic-shifted right by winShift (floor toward minus infinity); result fits W exactly.
REQ-024 Sum mode: op lane = accumulator saturated to [-(2^(W-1)), 2^(W-1)-1].
REQ-025 Bypass mode: window forced to 1 beat regardless of winShift; op = ip registered.
REQ-026 Window-closing beat to opValid latency: exactly 1 cycle (op registered).
REQ-027 op and opValid stable while opValid && !opReady.
REQ-028 In OUT with opReady && ipValid: result consumed and new beat accepted same cycle as count 1 of next window (or closes a 1-beat window, staying in OUT); no bubble.
REQ-029 In OUT with opReady && !ipValid: state -> ACC, opValid low next cycle.
REQ-030 flush in ACC: counter and accumulators cleared next cycle, beat presented that cycle not accepted (ipReady forced low); no output.
REQ-031 flush in OUT: pending result still delivered; flush has no effect.
REQ-032 busy = (count != 0) || opValid.

Reset
REQ-033 On RST: state ACC, count 0, accumulators 0, op 0, opValid 0; ipReady 1 next cycle.
REQ-034 RST mid-window or with result pending discards all data; RST overrides flush and handshakes in the same cycle.

Verification
(D=2, W=16, WS=2 for all.)
REQ-035 Max, winShift=2, lane0 beats 3,-7,12,5, lane1 -1,-9,-4,-2 -> one op, lane0=12, lane1=-1, opValid 1 cycle after beat 4.
REQ-036 Average, winShift=1, lane0 beats -3,-4 -> lane0=-4 (floor of -3.5); beats 7,8 -> 7.
REQ-037 Sum, winShift=2, lane0 four beats of 0x7000 -> lane0=0x7FFF; four beats of 0x9000 -> 0x8000.
REQ-038 Bypass, opReady held low 3 cycles after first result -> op stable, ipReady 0, then continuous ipValid/opReady -> one result per cycle, no bubble.
REQ-039 Max, winShift=2, two beats then flush, then 4 beats 1,2,3,4 -> single op lane0=4; pre-flush beats never appear.
REQ-040 RST asserted after 3 of 4 beats -> opValid 0, busy 0 next cycle; following 4-beat window produces a correct result unaffected by pre-reset data.
